// File: rtl/tetris_input_pkg.sv
// -----------------------------------------------------------------------------
// tetris_input_pkg
// Shared types and constants for the Tetris input scheduler:
//   cmd_t        - command codes presented to the game logic
//   BTN_*        - bit positions of each button in the debounced level vector
//   REPEAT_MASK  - buttons that auto-repeat while held (left, right, soft drop)
//   PRIO_ORDER   - arbitration order, highest priority in the top 3-bit slice
//   pick_winner  - returns the index of the highest-priority pending button
//   btn_to_cmd   - maps a button index to its command code
// -----------------------------------------------------------------------------
package tetris_input_pkg;

  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_LEFT   = 3'd1,
    CMD_RIGHT  = 3'd2,
    CMD_ROTATE = 3'd3,
    CMD_SOFT   = 3'd4,
    CMD_HARD   = 3'd5
  } cmd_t;

  typedef enum logic [1:0] {
    REP_IDLE = 2'd0,
    REP_DAS  = 2'd1,
    REP_ARR  = 2'd2
  } rep_state_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  localparam int unsigned NUM_BTN    = 5;
  localparam int unsigned BTN_LEFT   = 0;
  localparam int unsigned BTN_RIGHT  = 1;
  localparam int unsigned BTN_ROTATE = 2;
  localparam int unsigned BTN_SOFT   = 3;
  localparam int unsigned BTN_HARD   = 4;

  localparam logic [4:0] REPEAT_MASK = 5'b01011;

  // hard > rotate > left > right > soft (most significant slice wins)
  localparam logic [14:0] PRIO_ORDER = {3'(BTN_HARD), 3'(BTN_ROTATE), 3'(BTN_LEFT),
                                        3'(BTN_RIGHT), 3'(BTN_SOFT)};

  // Walk from lowest to highest priority so the last hit is the winner.
  function automatic logic [2:0] pick_winner(input logic [4:0] pend);
    logic [2:0] idx;
    logic [2:0] win;
    win = 3'd0;
    for (int k = 0; k < 5; k++) begin
      idx = PRIO_ORDER[3*k +: 3];
      if (pend[idx]) begin
        win = idx;
      end else begin
        win = win;
      end
    end
    return win;
  endfunction

  function automatic cmd_t btn_to_cmd(input logic [2:0] idx);
    return cmd_t'(idx + 3'd1);
  endfunction

endpackage

// File: rtl/tetris_input_scheduler_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Free-running divider producing a one-cycle tick every CLK_HZ/TICK_HZ clocks,
// counted from the end of reset (same counter pattern as the debouncers).
// Ports:
//   clk   in  system clock
//   reset in  synchronous, active-high
//   tick  out one-cycle pulse per timebase period
// -----------------------------------------------------------------------------
module tick_gen #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    if (cnt_q == CW'(DIV - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign tick = (cnt_q == CW'(DIV - 1));

endmodule

// File: rtl/tetris_input_scheduler.sv
// -----------------------------------------------------------------------------
// tetris_input_scheduler
// Turns five debounced button levels into single game commands on a
// valid/ready handshake. Presses are edge-detected into one pending bit per
// button; left/right/soft additionally auto-repeat while held when the
// AUTO_REPEAT_EN macro is defined (otherwise each press yields one command).
// A fixed-priority arbiter feeds a one-entry output register.
// Ports:
//   clk       in  system clock
//   reset     in  synchronous, active-high
//   btn_db    in  [0] left [1] right [2] rotate [3] soft drop [4] hard drop
//   cmd_valid out a command is offered
//   cmd       out command code (0 none .. 5 hard)
//   cmd_ready in  game logic accepts the command
// -----------------------------------------------------------------------------
module tetris_input_scheduler
  import tetris_input_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned TICK_HZ   = 100,
  parameter int unsigned DAS_TICKS = 17,
  parameter int unsigned ARR_TICKS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] btn_db,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  input  logic       cmd_ready
);

  logic [4:0] btn_q;
  logic [4:0] pend_q, pend_d;
  out_state_t out_state_q, out_state_d;
  cmd_t       cmd_q, cmd_d;

  logic [4:0] rise_s;
  logic [4:0] rep_set_s;
  logic [4:0] clr_s;
  logic       load_s;
  logic [2:0] win_s;

  // btn_q resets to all ones so a button held through reset is not a press
  assign rise_s = btn_db & ~btn_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q  <= 5'b11111;
      pend_q <= 5'b00000;
    end else begin
      btn_q  <= btn_db;
      pend_q <= pend_d;
    end
  end

  // a set in the same cycle as the clear keeps the bit pending
  always_comb begin
    win_s  = pick_winner(pend_q);
    pend_d = (pend_q & ~clr_s) | (rise_s | rep_set_s);
  end

  // ---------------------------------------------------------------- output FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      out_state_q <= OUT_EMPTY;
      cmd_q       <= CMD_NONE;
    end else begin
      out_state_q <= out_state_d;
      cmd_q       <= cmd_d;
    end
  end

  always_comb begin
    out_state_d = out_state_q;
    load_s      = 1'b0;
    case (out_state_q)
      OUT_EMPTY: begin
        if (|pend_q) begin
          out_state_d = OUT_FULL;
          load_s      = 1'b1;
        end else begin
          out_state_d = OUT_EMPTY;
        end
      end
      OUT_FULL: begin
        // back-to-back reload on the accepting cycle when more is pending
        if (cmd_ready && (|pend_q)) begin
          load_s = 1'b1;
        end else if (cmd_ready) begin
          out_state_d = OUT_EMPTY;
        end else begin
          out_state_d = OUT_FULL;
        end
      end
      default: begin
        out_state_d = OUT_EMPTY;
      end
    endcase
  end

  always_comb begin
    if (load_s) begin
      cmd_d = btn_to_cmd(win_s);
      clr_s = 5'b00001 << win_s;
    end else if (out_state_d == OUT_EMPTY) begin
      cmd_d = CMD_NONE;
      clr_s = 5'b00000;
    end else begin
      cmd_d = cmd_q;
      clr_s = 5'b00000;
    end
  end

  assign cmd_valid = (out_state_q == OUT_FULL);
  assign cmd       = cmd_q;

  // -------------------------------------------------------------- auto repeat
`ifdef AUTO_REPEAT_EN
  localparam int unsigned MAX_T = (DAS_TICKS > ARR_TICKS) ? DAS_TICKS : ARR_TICKS;
  localparam int unsigned CNT_W = $clog2(MAX_T + 1);

  logic tick_s;

  tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .tick (tick_s)
  );

  for (genvar i = 0; i < 5; i++) begin : g_rep
    if (REPEAT_MASK[i]) begin : g_fsm
      rep_state_t       state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             rep_s;

      always_ff @(posedge clk) begin
        if (reset) begin
          state_q <= REP_IDLE;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      // release overrides everything and returns to IDLE
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!btn_db[i]) begin
          state_d = REP_IDLE;
          cnt_d   = '0;
        end else begin
          case (state_q)
            REP_IDLE: begin
              if (rise_s[i]) begin
                state_d = REP_DAS;
                cnt_d   = CNT_W'(DAS_TICKS);
              end else begin
                state_d = REP_IDLE;
              end
            end
            REP_DAS, REP_ARR: begin
              if (tick_s && (cnt_q == CNT_W'(1))) begin
                state_d = REP_ARR;
                cnt_d   = CNT_W'(ARR_TICKS);
              end else if (tick_s) begin
                cnt_d = cnt_q - CNT_W'(1);
              end else begin
                cnt_d = cnt_q;
              end
            end
            default: begin
              state_d = REP_IDLE;
              cnt_d   = '0;
            end
          endcase
        end
      end

      always_comb begin
        rep_s = btn_db[i] && tick_s && (state_q != REP_IDLE) && (cnt_q == CNT_W'(1));
      end

      assign rep_set_s[i] = rep_s;
    end else begin : g_none
      assign rep_set_s[i] = 1'b0;
    end
  end
`else
  logic unused_cfg_s;

  assign rep_set_s    = 5'b00000;
  assign unused_cfg_s = ^{CLK_HZ, TICK_HZ, DAS_TICKS, ARR_TICKS};
`endif

endmodule

// File: tb/tb_tetris_input_scheduler.sv
module tb_tetris_input_scheduler;

  localparam int unsigned CLK_HZ  = 1000;
  localparam int unsigned TICK_HZ = 100;
  localparam int unsigned DAS     = 3;
  localparam int unsigned ARR     = 2;
  localparam int unsigned PERIOD  = CLK_HZ / TICK_HZ;

`ifdef AUTO_REPEAT_EN
  localparam int EXP_HOLD  = 5;  // press + repeats at ticks 3,5,7,9 of 10
  localparam int EXP_STALL = 2;  // held command + one collapsed repeat
`else
  localparam int EXP_HOLD  = 1;
  localparam int EXP_STALL = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] btn_db = 5'b00000;
  logic       cmd_ready = 1'b1;
  logic       cmd_valid;
  logic [2:0] cmd;

  int n_checks = 0;
  int n_fail   = 0;
  int acc [8];

  tetris_input_scheduler #(
    .CLK_HZ   (CLK_HZ),
    .TICK_HZ  (TICK_HZ),
    .DAS_TICKS(DAS),
    .ARR_TICKS(ARR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_db   (btn_db),
    .cmd_valid(cmd_valid),
    .cmd      (cmd),
    .cmd_ready(cmd_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ reference model
  bit         m_init = 1'b0;
  bit         m_valid;
  bit [2:0]   m_cmd;
  bit         m_chk;
  bit [4:0]   m_pend;
  bit [4:0]   m_prev;
  int         m_tcount;
`ifdef AUTO_REPEAT_EN
  bit         m_active [5];
  int         m_ticks  [5];
`endif
  int         prio [5] = '{4, 2, 0, 1, 3};

  task automatic model_step();
    bit [4:0] rise;
    bit [4:0] rep;
    bit       tick;
    int       w;
    if (reset) begin
      m_init = 1'b1;
      m_valid = 1'b0; m_cmd = 3'd0; m_chk = 1'b1;
      m_pend = 5'b0; m_prev = 5'b11111; m_tcount = 0;
`ifdef AUTO_REPEAT_EN
      for (int b = 0; b < 5; b++) begin m_active[b] = 1'b0; m_ticks[b] = 0; end
`endif
    end else begin
      tick = ((m_tcount % PERIOD) == PERIOD - 1);
      m_tcount++;
      rise = btn_db & ~m_prev;
      rep = 5'b0;
`ifdef AUTO_REPEAT_EN
      // a repeat fires on the DAS-th tick held after the press, then every ARR
      for (int b = 0; b < 5; b++) begin
        if (b == 0 || b == 1 || b == 3) begin
          if (!btn_db[b]) begin
            m_active[b] = 1'b0; m_ticks[b] = 0;
          end else if (rise[b]) begin
            m_active[b] = 1'b1; m_ticks[b] = 0;
          end else if (m_active[b] && tick) begin
            m_ticks[b]++;
            if (m_ticks[b] >= DAS && ((m_ticks[b] - DAS) % ARR) == 0) rep[b] = 1'b1;
          end
        end
      end
`else
      if (tick) rep = 5'b0;
`endif
      if (!m_valid || cmd_ready) begin
        w = -1;
        for (int p = 0; p < 5; p++)
          if (w < 0 && m_pend[prio[p]]) w = prio[p];
        if (w >= 0) begin
          m_valid = 1'b1; m_cmd = 3'(w + 1); m_chk = 1'b1; m_pend[w] = 1'b0;
        end else begin
          m_valid = 1'b0; m_chk = 1'b0;
        end
      end
      m_pend = m_pend | rise | rep;
      m_prev = btn_db;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // compare DUT against the model away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin
        check("model_valid", {7'd0, cmd_valid}, {7'd0, m_valid});
        if (m_chk) check("model_cmd", {5'd0, cmd}, {5'd0, m_cmd});
      end
    end
  end

  // count accepted commands per code
  always @(posedge clk) begin
    if (!reset && cmd_valid && cmd_ready) acc[cmd] <= acc[cmd] + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [4:0] hold_btn);
    @(negedge clk);
    reset = 1'b1;
    btn_db = hold_btn;
    cyc(2);
    check("reset_valid", {7'd0, cmd_valid}, 8'd0);
    check("reset_cmd", {5'd0, cmd}, 8'd0);
    reset = 1'b0;
  endtask

  int base;

  initial begin
    // rotate pulse: one command two cycles after the rise, nothing more
    do_reset(5'b00000);
    base = acc[3];
    cyc(1); btn_db = 5'b00100;
    cyc(1); btn_db = 5'b00000;
    check("rot_not_yet", {7'd0, cmd_valid}, 8'd0);
    cyc(1);
    check("rot_valid", {7'd0, cmd_valid}, 8'd1);
    check("rot_cmd", {5'd0, cmd}, 8'd3);
    cyc(1);
    check("rot_one_cycle", {7'd0, cmd_valid}, 8'd0);
    cyc(30);
    check("rot_count", 8'(acc[3] - base), 8'd1);

    // hard + rotate + left together: back-to-back 5, 3, 1
    do_reset(5'b00000);
    cyc(1); btn_db = 5'b10101;
    cyc(1); btn_db = 5'b00000;
    cyc(1); check("b2b_first", {5'd0, cmd}, 8'd5);
    cyc(1); check("b2b_second", {5'd0, cmd}, 8'd3);
    cyc(1); check("b2b_third", {5'd0, cmd}, 8'd1);
            check("b2b_third_v", {7'd0, cmd_valid}, 8'd1);
    cyc(1); check("b2b_done", {7'd0, cmd_valid}, 8'd0);
    cyc(10);

    // left held for 100 cycles
    do_reset(5'b00000);
    base = acc[1];
    cyc(1); btn_db = 5'b00001;
    cyc(2);
    check("hold_first_v", {7'd0, cmd_valid}, 8'd1);
    check("hold_first_c", {5'd0, cmd}, 8'd1);
    cyc(98); btn_db = 5'b00000;
    cyc(30);
    check("hold_count", 8'(acc[1] - base), 8'(EXP_HOLD));

    // ready low for 50 cycles while left is held
    cmd_ready = 1'b0;
    do_reset(5'b00000);
    base = acc[1];
    cyc(1); btn_db = 5'b00001;
    cyc(2);
    check("stall_v", {7'd0, cmd_valid}, 8'd1);
    check("stall_c", {5'd0, cmd}, 8'd1);
    cyc(48);
    check("stall_hold_v", {7'd0, cmd_valid}, 8'd1);
    check("stall_hold_c", {5'd0, cmd}, 8'd1);
    cmd_ready = 1'b1;
    cyc(1); btn_db = 5'b00000;
    cyc(20);
    check("stall_count", 8'(acc[1] - base), 8'(EXP_STALL));

    // rotate held through reset counts only after release and re-press
    do_reset(5'b00100);
    base = acc[3];
    cyc(20);
    check("held_reset_none", 8'(acc[3] - base), 8'd0);
    btn_db = 5'b00000;
    cyc(2); btn_db = 5'b00100;
    cyc(1); btn_db = 5'b00000;
    cyc(5);
    check("held_reset_repress", 8'(acc[3] - base), 8'd1);

    // reset while a command is offered drops it
    cmd_ready = 1'b0;
    btn_db = 5'b10000;
    cyc(1); btn_db = 5'b00000;
    cyc(1);
    check("pre_reset_v", {7'd0, cmd_valid}, 8'd1);
    check("pre_reset_c", {5'd0, cmd}, 8'd5);
    reset = 1'b1;
    cyc(1);
    check("mid_reset_v", {7'd0, cmd_valid}, 8'd0);
    check("mid_reset_c", {5'd0, cmd}, 8'd0);
    reset = 1'b0;
    cmd_ready = 1'b1;
    cyc(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tetris_input_scheduler.md
# tetris_input_scheduler

Converts the five debounced Tetris button levels into single game commands on a valid/ready handshake. Each press produces one command. Left, right and soft-drop also auto-repeat while held, after an initial delay. When several commands are pending it picks one by fixed priority. It sits between the per-button debouncers and the game-logic FSM.

## Interface
- CLK_HZ, 100_000_000, system clock frequency
- TICK_HZ, 100, repeat timebase rate (10 ms tick)
- DAS_TICKS, 17, ticks from press to first repeat (≥1)
- ARR_TICKS, 5, ticks between later repeats (≥1)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- btn_db  in  5  debounced levels: [0] left, [1] right, [2] rotate, [3] soft drop, [4] hard drop
- cmd_valid  out  1  a command is offered
- cmd  out  3  command code: 0 none, 1 left, 2 right, 3 rotate, 4 soft, 5 hard
- cmd_ready  in  1  game logic accepts the command

One clock domain. Reset is synchronous and active-high.

## Operation
- Edge detect
  - btn_q registers btn_db.
  - rise = btn_db & ~btn_q.
  - Reset loads btn_q to all ones, so a button held through reset must be released before it counts.
- Pending bits
  - There is one pending bit per button.
  - It is set by a rise or by a repeat expiry.
  - It is cleared when its command is loaded into the output register.
  - If a set and a clear happen in the same cycle, the set wins.
  - A set on a bit that is already pending has no effect. There is no queue depth beyond one per button.
  - A pending bit survives the button's release, so a brief press is never lost.
- Repeat FSM, one per repeatable button (left, right, soft; REPEAT_MASK = 5'b01011)
  - States: IDLE, DAS, ARR.
  - IDLE -> DAS on rise; cnt = DAS_TICKS.
  - DAS or ARR: on tick, cnt decrements. On tick with cnt==1, set pending, go to ARR, load cnt = ARR_TICKS.
  - Any state -> IDLE when btn_db goes low; cnt = 0.
  - Rotate and hard drop never repeat.
- Arbitration: fixed priority hard > rotate > left > right > soft. Left and right held together both repeat, and left wins each conflict.
- Output register, two states
  - EMPTY: cmd_valid=0. If any pending bit is set, load the winner's code, set cmd_valid, and clear that pending bit.
  - FULL: cmd and cmd_valid hold while cmd_ready=0. On cmd_valid&cmd_ready, load the next winner in the same cycle if one is pending (back-to-back). Otherwise return to EMPTY.
- Reset during a handshake drops the offered command and all pending bits.

## Timing
- Reset values: cmd_valid=0, cmd=0, all pending bits 0, all repeat FSMs IDLE, tick counter 0.
- A rise seen at cycle N sets the pending bit at N+1. cmd_valid rises at N+2 if the output register is EMPTY.
- tick is a 1-cycle pulse every CLK_HZ/TICK_HZ cycles, counted from the end of reset. The counter width is $clog2(CLK_HZ/TICK_HZ).
- First repeat comes DAS_TICKS ticks after the press; the first tick may be partial, ±1 tick. After that, one repeat every ARR_TICKS ticks.
- cmd_valid never drops without cmd_ready, except on reset.

## Configuration
- AUTO_REPEAT_EN defined: repeat FSMs, counters and the tick generator are built as described above.
- AUTO_REPEAT_EN undefined:
  - Each rise yields exactly one command.
  - Holding a button generates nothing more.
  - DAS_TICKS, ARR_TICKS and TICK_HZ are ignored.
  - The tick generator is not instantiated.

## Structure
- Package tetris_input_pkg holds:
  - cmd_t enum (CMD_NONE..CMD_HARD)
  - button index constants BTN_LEFT..BTN_HARD
  - REPEAT_MASK
  - the priority order
- Sub-module tick_gen(clk, reset, tick), parameterised by CLK_HZ/TICK_HZ. It follows the 10 ms counter pattern already used by the debouncers.

## Test plan
Bench settings: CLK_HZ=1000, TICK_HZ=100 (tick every 10 cycles), DAS_TICKS=3, ARR_TICKS=2, cmd_ready=1 unless stated.
- Rotate pulsed high for 1 cycle at N -> cmd=3 with cmd_valid at N+2 for exactly one cycle, and no further command.
- Left held for 100 cycles -> one cmd=1 at press+2, then repeats about 30 cycles later and every 20 cycles after that, stopping once left is released.
- Hard, rotate and left all rise in the same cycle with cmd_ready=1 -> back-to-back cmd=5, 3, 1 on consecutive cycles.
- cmd_ready=0 for 50 cycles while left repeats -> cmd=1 held stable, and exactly one more left is delivered after ready returns (repeats collapse into one).
- Button held across reset -> no command until it is released and pressed again. Reset asserted while cmd_valid=1 -> cmd_valid=0 and cmd=0 on the next cycle.
- Built without AUTO_REPEAT_EN, left held for 100 cycles -> exactly one cmd=1.
